// File: rtl/rc_filter_mc_if.sv
// Stream interface of rc_filter_mc.
//   in_valid/in_ready/in_ch/in_data     : sample input handshake
//   out_valid/out_ready/out_ch/out_data : filtered result handshake
// The master modport is the side that supplies samples and consumes results.
// The slave modport is the filter side.
interface rc_filter_mc_if #(
    parameter int CH_W  = 2,
    parameter int WIDTH = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [CH_W-1:0]         in_ch;
    logic signed [WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [CH_W-1:0]         out_ch;
    logic signed [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_ch, in_data, out_ready,
        input  in_ready, out_valid, out_ch, out_data
    );

    modport slave (
        input  in_valid, in_ch, in_data, out_ready,
        output in_ready, out_valid, out_ch, out_data
    );
endinterface

// File: rtl/rc_filter_mc.sv
// Time-multiplexed N-channel first-order RC low-pass filter.
// Each accepted sample updates its channel:
//   state[k] <= state[k] + round(coef[k] / 2^COEF_W * (in - state[k])).
// One shared multiplier sits behind a two-stage valid/ready pipeline:
// S1 captures the operands, S2 registers the result and writes the state.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : sample input and result output handshakes
//   cfg_we/ch/coef    : per-channel coefficient write
//   clr               : per-channel state clear mask (one-cycle pulse)
module rc_filter_mc #(
    parameter int          N_CH     = 4,
    parameter int          WIDTH    = 16,
    parameter int          COEF_W   = 16,
    parameter int unsigned COEF_RST = 2 ** (COEF_W - 1),
    localparam int         CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    rc_filter_mc_if.slave     bus,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [COEF_W-1:0] cfg_coef,
    input  logic [N_CH-1:0]   clr
);
    localparam int              PW   = WIDTH + COEF_W + 2;
    localparam logic [CH_W:0]   CHN  = (CH_W + 1)'(N_CH);
    localparam logic [PW-1:0]   HALF = PW'(1) << (COEF_W - 1);

    logic signed [WIDTH-1:0] state_q [N_CH];
    logic [COEF_W-1:0]       coef_q  [N_CH];

    logic                    s1_valid_q;
    logic [CH_W-1:0]         s1_ch_q;
    logic signed [WIDTH-1:0] s1_data_q;
    logic signed [WIDTH-1:0] s1_state_q;
    logic [COEF_W-1:0]       s1_coef_q;

    logic                    out_valid_q;
    logic [CH_W-1:0]         out_ch_q;
    logic signed [WIDTH-1:0] out_data_q;

    logic                    advance;
    logic                    in_ch_ok;
    logic                    cfg_ch_ok;
    logic                    in_fire;
    logic signed [WIDTH-1:0] s1_state_d;
    logic [COEF_W-1:0]       s1_coef_d;

    logic signed [WIDTH:0]   delta;
    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    rnd;
    logic signed [WIDTH-1:0] step;
    logic signed [WIDTH-1:0] new_state;

    // Result of the sample currently in S1; |step| <= |delta| so it cannot wrap.
    always_comb begin
        delta     = {s1_data_q[WIDTH-1], s1_data_q} - {s1_state_q[WIDTH-1], s1_state_q};
        prod      = PW'(delta) * $signed(PW'({1'b0, s1_coef_q}));
        rnd       = prod + $signed(HALF);
        step      = WIDTH'(rnd >>> COEF_W);
        new_state = s1_state_q + step;
    end

    always_comb begin
        advance   = !out_valid_q || bus.out_ready;
        in_ch_ok  = ({1'b0, bus.in_ch} < CHN);
        cfg_ch_ok = ({1'b0, cfg_ch} < CHN);
        // Out-of-range channels are still handshaked, but never enter S1.
        in_fire   = bus.in_valid && advance && !rst && in_ch_ok;

        s1_coef_d  = '0;
        s1_state_d = '0;
        if (in_ch_ok) begin
            s1_coef_d  = coef_q[bus.in_ch];
            s1_state_d = state_q[bus.in_ch];
        end
        // Forward the value S2 writes on this same edge; a clear on this edge overrides it.
        if (advance && s1_valid_q && (s1_ch_q == bus.in_ch)) begin
            s1_state_d = new_state;
        end
        if (in_ch_ok && clr[bus.in_ch]) begin
            s1_state_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                state_q[k] <= '0;
                coef_q[k]  <= COEF_W'(COEF_RST);
            end
            s1_valid_q  <= 1'b0;
            s1_ch_q     <= '0;
            s1_data_q   <= '0;
            s1_state_q  <= '0;
            s1_coef_q   <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
        end else begin
            if (cfg_we && cfg_ch_ok) begin
                coef_q[cfg_ch] <= cfg_coef;
            end
            if (advance) begin
                s1_valid_q <= in_fire;
                if (in_fire) begin
                    s1_ch_q    <= bus.in_ch;
                    s1_data_q  <= bus.in_data;
                    s1_state_q <= s1_state_d;
                    s1_coef_q  <= s1_coef_d;
                end
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_ch_q          <= s1_ch_q;
                    out_data_q        <= new_state;
                    state_q[s1_ch_q]  <= new_state;
                end
            end
            // Placed after the S2 write so a clear on the same channel wins.
            for (int unsigned k = 0; k < N_CH; k++) begin
                if (clr[k]) begin
                    state_q[k] <= '0;
                end
            end
        end
    end

    assign bus.in_ready  = advance && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_data  = out_data_q;
endmodule
